// File: rtl/mux_8to1_reg_if.sv
// Bundle for the registered 8-to-1 mux: eight data sources, select, enable,
// and the registered result with its capture strobe.
interface mux_8to1_reg_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic [2:0]       sel;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic [WIDTH-1:0] i4;
  logic [WIDTH-1:0] i5;
  logic [WIDTH-1:0] i6;
  logic [WIDTH-1:0] i7;
  logic [WIDTH-1:0] o;
  logic             o_valid;

  modport master (
    output en, sel, i0, i1, i2, i3, i4, i5, i6, i7,
    input  o, o_valid
  );

  modport slave (
    input  en, sel, i0, i1, i2, i3, i4, i5, i6, i7,
    output o, o_valid
  );
endinterface

// File: rtl/mux_8to1_reg.sv
// Registered 8-to-1 multiplexer: selects one of eight WIDTH-bit words, captures
// it when enabled and raises a one-cycle valid per capture.
module mux_8to1_reg #(
  parameter int unsigned WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  mux_8to1_reg_if.slave  bus
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // Every 3-bit code maps to an input, so no default arm is needed.
  always_comb begin
    sel_data = '0;
    unique case (bus.sel)
      3'd0: sel_data = bus.i0;
      3'd1: sel_data = bus.i1;
      3'd2: sel_data = bus.i2;
      3'd3: sel_data = bus.i3;
      3'd4: sel_data = bus.i4;
      3'd5: sel_data = bus.i5;
      3'd6: sel_data = bus.i6;
      3'd7: sel_data = bus.i7;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.en;
      if (bus.en) begin
        data_q <= sel_data;
      end
    end
  end

  assign bus.o       = data_q;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_mux_8to1_reg.sv
// Scoreboard bench for mux_8to1_reg: stimulus pushes the expected word on each
// capture request, a monitor pops and compares whenever o_valid is seen.
module tb_mux_8to1_reg;

  logic clk = 1'b0;
  logic rst_n;

  mux_8to1_reg_if #(.WIDTH(16)) ifc ();
  mux_8to1_reg_if #(.WIDTH(8))  ifc8 ();

  mux_8to1_reg #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  mux_8to1_reg #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc8)
  );

  always #5 clk = ~clk;

  logic [15:0] din [8];
  logic [15:0] exp_q [$];
  logic [15:0] last_exp = '0;
  int          n_checks = 0;
  int          n_pass   = 0;

  assign ifc.i0 = din[0];
  assign ifc.i1 = din[1];
  assign ifc.i2 = din[2];
  assign ifc.i3 = din[3];
  assign ifc.i4 = din[4];
  assign ifc.i5 = din[5];
  assign ifc.i6 = din[6];
  assign ifc.i7 = din[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Reference: a capture of raw select s yields din[s mod 8]; nothing is
  // expected while reset is held.
  task automatic step(input logic e, input int unsigned s);
    ifc.en  = e;
    ifc.sel = s[2:0];
    if (e && rst_n) exp_q.push_back(din[s % 8]);
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle sampling, decoupled from the stimulus.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_o", 32'(ifc.o), 32'd0);
      chk("reset_valid", 32'(ifc.o_valid), 32'd0);
    end else if (ifc.o_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got o=%0h with valid, expected no capture at %0t",
                 ifc.o, $time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("capture_o", 32'(ifc.o), 32'(e));
        last_exp = e;
      end
    end else begin
      chk("hold_o", 32'(ifc.o), 32'(last_exp));
    end
  end

  initial begin
    rst_n   = 1'b0;
    ifc.en  = 1'b1;
    ifc.sel = 3'd3;
    for (int k = 0; k < 8; k++) din[k] = 16'(k + 1);
    ifc8.en  = 1'b0;
    ifc8.sel = 3'd0;
    ifc8.i0 = 8'h10; ifc8.i1 = 8'h11; ifc8.i2 = 8'h12; ifc8.i3 = 8'h13;
    ifc8.i4 = 8'h14; ifc8.i5 = 8'h15; ifc8.i6 = 8'h16; ifc8.i7 = 8'h17;

    // Asynchronous reset visible before any edge; held across edges with en=1.
    #1;
    chk("t0_o", 32'(ifc.o), 32'd0);
    chk("t0_valid", 32'(ifc.o_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("in_reset_o", 32'(ifc.o), 32'd0);
    rst_n = 1'b1;
    step(1'b1, 3);
    chk("release_valid", 32'(ifc.o_valid), 32'd1);

    // Select sweep.
    for (int s = 0; s < 8; s++) step(1'b1, s);

    // 4-bit select value 8 wraps to input 0, then an updated i4.
    step(1'b1, 8);
    chk("wrap_o", 32'(ifc.o), 32'd1);
    din[4] = 16'd10;
    step(1'b1, 4);
    chk("update_o", 32'(ifc.o), 32'd10);

    // Enable hold.
    step(1'b1, 6);
    din[6] = 16'd99;
    step(1'b0, 2);
    chk("hold_direct_o", 32'(ifc.o), 32'd7);
    chk("hold_direct_valid", 32'(ifc.o_valid), 32'd0);
    step(1'b1, 2);
    chk("reenable_o", 32'(ifc.o), 32'd3);

    // Reset pulse between edges.
    din[4] = 16'd5;
    step(1'b1, 4);
    chk("pre_reset_o", 32'(ifc.o), 32'd5);
    #1;
    rst_n    = 1'b0;
    last_exp = '0;
    exp_q.delete();
    #1;
    chk("midreset_o", 32'(ifc.o), 32'd0);
    chk("midreset_valid", 32'(ifc.o_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    step(1'b1, 7);
    chk("post_reset_o", 32'(ifc.o), 32'd8);

    // Full-width data at both widths.
    din[2] = 16'hFFFF;
    step(1'b1, 2);
    chk("w16_o", 32'(ifc.o), 32'h0000FFFF);
    ifc8.i2  = 8'hA5;
    ifc8.sel = 3'd2;
    ifc8.en  = 1'b1;
    step(1'b0, 0);
    chk("w8_o", 32'(ifc8.o), 32'h000000A5);
    chk("w8_valid", 32'(ifc8.o_valid), 32'd1);
    ifc8.en = 1'b0;

    // Randomized traffic, including 4-bit selects that must wrap.
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) din[k] = 16'($urandom);
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15));
    end

    step(1'b0, 0);
    step(1'b0, 0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
